data_memory_stage: RTL and testbench
====================================

DATA_MEMORY_STAGE -- requirements
Module: data_memory_stage

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 mem_ir  input  32  instruction currently in the MEM stage; opcode = mem_ir[31:26].
REQ-004 mem_pc  input  32  PC of mem_ir; used only for the store trace.
REQ-005 mem_addr  input  32  byte address, i.e. the ALU result of the MEM-stage instruction.
REQ-006 mem_wdata  input  32  store data, the forwarded rt value.
REQ-007 mem_rdata  output  32  extended load result; feeds the write-back register's read-data field.
REQ-008 st_valid  output  1  registered pulse: a store committed on the previous edge.
REQ-009 st_pc / st_addr / st_data  output  32 each  registered PC, word-aligned address and merged word of that store.

Function
REQ-010 Storage SHALL be 3072 words x 32 bit, covering byte addresses 0x0000_0000-0x0000_2FFF, word index mem_addr[13:2].
REQ-011 Opcodes SHALL decode as: sw 101011, sh 101001, sb 101000, lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100; all others SHALL be non-memory.
REQ-012 Stores SHALL write on posedge clk when reset=0; loads SHALL be combinational (asynchronous read) with zero latency.
REQ-013 sw SHALL write the whole word and ignore mem_addr[1:0].
REQ-014 sh SHALL write mem_wdata[15:0] into half mem_addr[1]; bytes outside that half are untouched; mem_addr[0] is ignored.
REQ-015 sb SHALL write mem_wdata[7:0] into byte lane mem_addr[1:0]; other lanes are untouched. Lane 0 is bits [7:0] (little-endian).
REQ-016 lw SHALL return the word. lh/lhu SHALL return half mem_addr[1], sign- or zero-extended. lb/lbu SHALL return byte lane mem_addr[1:0], sign- or zero-extended.
REQ-017 For a non-load opcode, mem_rdata SHALL be 0.
REQ-018 Out of range (mem_addr >= 0x3000): stores SHALL be ignored with st_valid=0; loads SHALL return 0.
REQ-019 A load on the cycle after a store to the same word SHALL see the updated word.
REQ-020 When a store commits, the following cycle SHALL have st_valid=1, st_pc=mem_pc, st_addr={mem_addr[31:2],2'b00} and st_data = the full merged word after the write. Otherwise st_valid SHALL be 0 and the other trace outputs SHALL hold their values.
REQ-021 mem_ir=0 (nop/bubble) SHALL have no effect on storage.

Reset
REQ-022 On a reset edge, every storage word SHALL become 0x0000_0000.
REQ-023 On a reset edge, st_valid SHALL become 0 and st_pc/st_addr/st_data SHALL become 0x0000_0000.
REQ-024 A store presented on a reset edge SHALL be discarded; reset wins.
REQ-025 mem_rdata SHALL read 0 for any load in the cycle after reset.

Structure
REQ-026 A shared package SHALL hold the eight opcode constants, DM_WORDS=3072 and DM_LIMIT=32'h3000.
REQ-027 Load extension SHALL live in one sub-module, load_extend (inputs: opcode, addr[1:0], raw word; output: 32-bit result).
REQ-028 Byte-enable generation and write merge SHALL stay in data_memory_stage.

Verification
REQ-029 After reset: sw addr 0x0 data 0x12345678 -> st_valid=1, st_data=0x12345678. Then lw 0x0 -> 0x12345678. Then lb 0x3 -> 0x00000012. Then lbu 0x0 -> 0x00000078.
REQ-030 Starting from word 0x12345678: sb addr 0x1 data 0xFFFFFF80 -> word 0x12348078. Then lb 0x1 -> 0xFFFFFF80. Then lbu 0x1 -> 0x00000080.
REQ-031 sh addr 0x6 data 0x0000BEEF -> word 0x4 = 0xBEEF0000. Then lh 0x6 -> 0xFFFFBEEF. Then lhu 0x6 -> 0x0000BEEF. Then lh 0x4 -> 0x00000000.
REQ-032 Out of range: sw 0x3000 data 0xDEADBEEF -> st_valid=0 and no word changes. Then lw 0x3000 -> 0. Then sw 0x2FFC data 0xA5A5A5A5 followed by lw 0x2FFC -> 0xA5A5A5A5.
REQ-033 Reset mid-run: fill words 0-3 with nonzero data, then assert reset for 1 cycle together with an sw to 0x8 -> all loads return 0, and st_valid=0 after the edge.
REQ-034 Back-to-back: sb 0x10 data 0x11, sb 0x11 data 0x22, sh 0x12 data 0x3344 on consecutive cycles -> lw 0x10 returns 0x33442211, with three st_valid pulses whose st_data is 0x00000011, 0x00002211 and 0x33442211.

Source files
------------

// File: rtl/data_memory_stage_pkg.sv
// Shared constants and decode helpers for the MEM-stage data memory.
// Opcode values are the MIPS-style load/store encodings from mem_ir[31:26].
package data_memory_stage_pkg;

    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;

    localparam int          DM_WORDS = 3072;
    localparam int          DM_IDX_W = 12;
    localparam logic [31:0] DM_LIMIT = 32'h3000;

    typedef enum logic [1:0] {
        SZ_NONE,
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } store_size_e;

    function automatic store_size_e store_size(input logic [5:0] opcode);
        case (opcode)
            OP_SW:   return SZ_WORD;
            OP_SH:   return SZ_HALF;
            OP_SB:   return SZ_BYTE;
            default: return SZ_NONE;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_stage_if.sv
// MEM-stage bus: instruction/address/store data in, load data and store trace out.
// The pipeline side is the master; the data memory stage is the slave.
interface data_memory_stage_if;
    logic [31:0] mem_ir;
    logic [31:0] mem_pc;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        st_valid;
    logic [31:0] st_pc;
    logic [31:0] st_addr;
    logic [31:0] st_data;

    modport master (
        output mem_ir, mem_pc, mem_addr, mem_wdata,
        input  mem_rdata, st_valid, st_pc, st_addr, st_data
    );

    modport slave (
        input  mem_ir, mem_pc, mem_addr, mem_wdata,
        output mem_rdata, st_valid, st_pc, st_addr, st_data
    );
endinterface

// File: rtl/data_memory_stage_load_extend.sv
// Selects the half/byte lane of a raw memory word and sign- or zero-extends it.
// Non-load opcodes produce zero.
module load_extend
    import data_memory_stage_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] raw_word,
    output logic [31:0] result
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
        case (addr_lo)
            2'd0:    byte_sel = raw_word[7:0];
            2'd1:    byte_sel = raw_word[15:8];
            2'd2:    byte_sel = raw_word[23:16];
            default: byte_sel = raw_word[31:24];
        endcase

        result = '0;
        case (opcode)
            OP_LW:   result = raw_word;
            OP_LH:   result = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  result = {16'h0000, half_sel};
            OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  result = {24'h000000, byte_sel};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_stage.sv
// MEM-stage data memory: 3072-word storage with byte-lane store merge, asynchronous
// extended loads and a registered one-cycle trace of every committed store.
module data_memory_stage
    import data_memory_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    data_memory_stage_if.slave bus
);

    logic [31:0]         mem_q [DM_WORDS];
    logic [5:0]          opcode;
    logic                in_range;
    logic [DM_IDX_W-1:0] word_idx;
    logic [31:0]         cur_word;
    store_size_e         st_size;
    logic [3:0]          byte_en;
    logic [31:0]         lane_data;
    logic [31:0]         merged_word;
    logic                store_commit;

    logic        st_valid_d, st_valid_q;
    logic [31:0] st_pc_d,    st_pc_q;
    logic [31:0] st_addr_d,  st_addr_q;
    logic [31:0] st_data_d,  st_data_q;

    // Only the opcode field matters here; the rest of the instruction is decoded elsewhere.
    logic unused_ir;
    assign unused_ir = ^bus.mem_ir[25:0];

    assign opcode   = bus.mem_ir[31:26];
    assign in_range = (bus.mem_addr < DM_LIMIT);
    assign word_idx = bus.mem_addr[13:2];
    // Out-of-range addresses would alias into the array via [13:2]; force them to read zero.
    assign cur_word = in_range ? mem_q[word_idx] : 32'h0;
    assign st_size  = store_size(opcode);

    always_comb begin
        byte_en   = 4'b0000;
        lane_data = 32'h0;
        case (st_size)
            SZ_WORD: begin
                byte_en   = 4'b1111;
                lane_data = bus.mem_wdata;
            end
            SZ_HALF: begin
                byte_en   = bus.mem_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{bus.mem_wdata[15:0]}};
            end
            SZ_BYTE: begin
                byte_en   = 4'b0001 << bus.mem_addr[1:0];
                lane_data = {4{bus.mem_wdata[7:0]}};
            end
            default: begin
                byte_en   = 4'b0000;
                lane_data = 32'h0;
            end
        endcase

        for (int i = 0; i < 4; i++) begin
            merged_word[i*8 +: 8] = byte_en[i] ? lane_data[i*8 +: 8] : cur_word[i*8 +: 8];
        end
    end

    assign store_commit = (st_size != SZ_NONE) && in_range;

    always_comb begin
        st_valid_d = store_commit;
        st_pc_d    = st_pc_q;
        st_addr_d  = st_addr_q;
        st_data_d  = st_data_q;
        if (store_commit) begin
            st_pc_d   = bus.mem_pc;
            st_addr_d = {bus.mem_addr[31:2], 2'b00};
            st_data_d = merged_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (store_commit) begin
            mem_q[word_idx] <= merged_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_valid_q <= 1'b0;
            st_pc_q    <= 32'h0;
            st_addr_q  <= 32'h0;
            st_data_q  <= 32'h0;
        end else begin
            st_valid_q <= st_valid_d;
            st_pc_q    <= st_pc_d;
            st_addr_q  <= st_addr_d;
            st_data_q  <= st_data_d;
        end
    end

    load_extend u_load_extend (
        .opcode   (opcode),
        .addr_lo  (bus.mem_addr[1:0]),
        .raw_word (cur_word),
        .result   (bus.mem_rdata)
    );

    assign bus.st_valid = st_valid_q;
    assign bus.st_pc    = st_pc_q;
    assign bus.st_addr  = st_addr_q;
    assign bus.st_data  = st_data_q;

endmodule

// File: tb/tb_data_memory_stage.sv
// Directed bench for data_memory_stage: stores, extended loads, range limits,
// reset behaviour and back-to-back stores against hand-computed values.
module tb_data_memory_stage;
    import data_memory_stage_pkg::*;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    data_memory_stage_if bus ();

    data_memory_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded, got timeout exp completion");
        $fatal(1, "watchdog");
    end

    // Nonzero low instruction bits confirm only the opcode field is decoded.
    task automatic set_op(input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] pc);
        bus.mem_ir    = {op, 26'h1234567};
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_pc    = pc;
        #1;
    endtask

    task automatic set_nop();
        bus.mem_ir    = 32'h0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'hFFFF_FFFF;
        bus.mem_pc    = 32'h0;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_nop();
        step();
        step();
        reset = 1'b0;
        checks++;
        if (bus.st_valid !== 1'b0) begin
            errors++; $display("FAIL reset_st_valid: got %b exp 0", bus.st_valid);
        end
        checks++;
        if ({bus.st_pc, bus.st_addr, bus.st_data} !== 96'h0) begin
            errors++; $display("FAIL reset_trace: got pc=%h addr=%h data=%h exp all 0",
                               bus.st_pc, bus.st_addr, bus.st_data);
        end
        set_op(OP_LW, 32'h0, 32'h0, 32'h0);
        checks++;
        if (bus.mem_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_lw0: got %h exp 00000000", bus.mem_rdata);
        end
    endtask

    task automatic test_word_byte();
        set_op(OP_SW, 32'h0, 32'h12345678, 32'h0000_0100);
        step();
        checks++;
        if (bus.st_valid !== 1'b1 || bus.st_data !== 32'h12345678 ||
            bus.st_addr !== 32'h0 || bus.st_pc !== 32'h100) begin
            errors++; $display("FAIL sw_trace: got v=%b pc=%h addr=%h data=%h exp v=1 pc=00000100 addr=00000000 data=12345678",
                               bus.st_valid, bus.st_pc, bus.st_addr, bus.st_data);
        end
        set_op(OP_LW, 32'h0, 32'h0, 32'h0);
        checks++;
        if (bus.mem_rdata !== 32'h12345678) begin
            errors++; $display("FAIL lw_0: got %h exp 12345678", bus.mem_rdata);
        end
        step();
        checks++;
        if (bus.st_valid !== 1'b0 || bus.st_pc !== 32'h100 || bus.st_data !== 32'h12345678) begin
            errors++; $display("FAIL trace_hold: got v=%b pc=%h data=%h exp v=0 pc=00000100 data=12345678",
                               bus.st_valid, bus.st_pc, bus.st_data);
        end
        set_op(OP_LB, 32'h3, 32'h0, 32'h0);
        checks++;
        if (bus.mem_rdata !== 32'h00000012) begin
            errors++; $display("FAIL lb_3: got %h exp 00000012", bus.mem_rdata);
        end
        set_op(OP_LBU, 32'h0, 32'h0, 32'h0);
        checks++;
        if (bus.mem_rdata !== 32'h00000078) begin
            errors++; $display("FAIL lbu_0: got %h exp 00000078", bus.mem_rdata);
        end
        set_op(OP_LH, 32'h2, 32'h0, 32'h0);
        checks++;
        if (bus.mem_rdata !== 32'h00001234) begin
            errors++; $display("FAIL lh_2: got %h exp 00001234", bus.mem_rdata);
        end
    endtask

    task automatic test_byte_store();
        set_op(OP_SB, 32'h1, 32'hFFFFFF80, 32'h0000_0104);
        step();
        checks++;
        if (bus.st_valid !== 1'b1 || bus.st_data !== 32'h12348078) begin
            errors++; $display("FAIL sb_trace: got v=%b data=%h exp v=1 data=12348078",
                               bus.st_valid, bus.st_data);
        end
        set_op(OP_LB, 32'h1, 32'h0, 32'h0);
        checks++;
        if (bus.mem_rdata !== 32'hFFFFFF80) begin
            errors++; $display("FAIL lb_1: got %h exp ffffff80", bus.mem_rdata);
        end
        set_op(OP_LBU, 32'h1, 32'h0, 32'h0);
        checks++;
        if (bus.mem_rdata !== 32'h00000080) begin
            errors++; $display("FAIL lbu_1: got %h exp 00000080", bus.mem_rdata);
        end
        set_op(OP_LB, 32'h2, 32'h0, 32'h0);
        checks++;
        if (bus.mem_rdata !== 32'h00000034) begin
            errors++; $display("FAIL lb_2: got %h exp 00000034", bus.mem_rdata);
        end
        step();
    endtask

    task automatic test_half();
        set_op(OP_SH, 32'h6, 32'h0000BEEF, 32'h0000_0108);
        step();
        checks++;
        if (bus.st_valid !== 1'b1 || bus.st_addr !== 32'h4 || bus.st_data !== 32'hBEEF0000) begin
            errors++; $display("FAIL sh_trace: got v=%b addr=%h data=%h exp v=1 addr=00000004 data=beef0000",
                               bus.st_valid, bus.st_addr, bus.st_data);
        end
        set_op(OP_LH, 32'h6, 32'h0, 32'h0);
        checks++;
        if (bus.mem_rdata !== 32'hFFFFBEEF) begin
            errors++; $display("FAIL lh_6: got %h exp ffffbeef", bus.mem_rdata);
        end
        set_op(OP_LHU, 32'h6, 32'h0, 32'h0);
        checks++;
        if (bus.mem_rdata !== 32'h0000BEEF) begin
            errors++; $display("FAIL lhu_6: got %h exp 0000beef", bus.mem_rdata);
        end
        set_op(OP_LH, 32'h4, 32'h0, 32'h0);
        checks++;
        if (bus.mem_rdata !== 32'h00000000) begin
            errors++; $display("FAIL lh_4: got %h exp 00000000", bus.mem_rdata);
        end
        set_op(OP_SH, 32'h5, 32'h00001357, 32'h0000_010C);
        step();
        checks++;
        if (bus.st_data !== 32'hBEEF1357) begin
            errors++; $display("FAIL sh_odd: got %h exp beef1357", bus.st_data);
        end
    endtask

    task automatic test_non_load();
        set_op(6'b001000, 32'h0, 32'hCAFEF00D, 32'h0000_0200);
        checks++;
        if (bus.mem_rdata !== 32'h0) begin
            errors++; $display("FAIL nonload_rdata: got %h exp 00000000", bus.mem_rdata);
        end
        step();
        checks++;
        if (bus.st_valid !== 1'b0) begin
            errors++; $display("FAIL nonload_st_valid: got %b exp 0", bus.st_valid);
        end
        set_nop();
        step();
        checks++;
        if (bus.st_valid !== 1'b0 || bus.st_data !== 32'hBEEF1357) begin
            errors++; $display("FAIL nop_trace: got v=%b data=%h exp v=0 data=beef1357",
                               bus.st_valid, bus.st_data);
        end
        set_op(OP_LW, 32'h0, 32'h0, 32'h0);
        checks++;
        if (bus.mem_rdata !== 32'h12348078) begin
            errors++; $display("FAIL nop_untouched: got %h exp 12348078", bus.mem_rdata);
        end
    endtask

    task automatic test_out_of_range();
        set_op(OP_SW, 32'h3000, 32'hDEADBEEF, 32'h0000_0300);
        step();
        checks++;
        if (bus.st_valid !== 1'b0 || bus.st_data !== 32'hBEEF1357) begin
            errors++; $display("FAIL oor_sw_trace: got v=%b data=%h exp v=0 data=beef1357",
                               bus.st_valid, bus.st_data);
        end
        set_op(OP_SW, 32'h4000, 32'hDEADBEEF, 32'h0000_0304);
        step();
        set_op(OP_LW, 32'h3000, 32'h0, 32'h0);
        checks++;
        if (bus.mem_rdata !== 32'h0) begin
            errors++; $display("FAIL oor_lw_3000: got %h exp 00000000", bus.mem_rdata);
        end
        set_op(OP_LW, 32'h4000, 32'h0, 32'h0);
        checks++;
        if (bus.mem_rdata !== 32'h0) begin
            errors++; $display("FAIL oor_lw_4000: got %h exp 00000000", bus.mem_rdata);
        end
        set_op(OP_LW, 32'h0, 32'h0, 32'h0);
        checks++;
        if (bus.mem_rdata !== 32'h12348078) begin
            errors++; $display("FAIL oor_no_alias: got %h exp 12348078", bus.mem_rdata);
        end
        set_op(OP_SW, 32'h2FFC, 32'hA5A5A5A5, 32'h0000_0308);
        step();
        checks++;
        if (bus.st_valid !== 1'b1 || bus.st_addr !== 32'h2FFC) begin
            errors++; $display("FAIL top_sw_trace: got v=%b addr=%h exp v=1 addr=00002ffc",
                               bus.st_valid, bus.st_addr);
        end
        set_op(OP_LW, 32'h2FFC, 32'h0, 32'h0);
        checks++;
        if (bus.mem_rdata !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL top_lw: got %h exp a5a5a5a5", bus.mem_rdata);
        end
        step();
    endtask

    task automatic test_back_to_back();
        set_op(OP_SB, 32'h10, 32'h00000011, 32'h0000_0400);
        step();
        checks++;
        if (bus.st_valid !== 1'b1 || bus.st_data !== 32'h00000011) begin
            errors++; $display("FAIL b2b_1: got v=%b data=%h exp v=1 data=00000011",
                               bus.st_valid, bus.st_data);
        end
        set_op(OP_SB, 32'h11, 32'h00000022, 32'h0000_0404);
        step();
        checks++;
        if (bus.st_valid !== 1'b1 || bus.st_data !== 32'h00002211 || bus.st_pc !== 32'h404) begin
            errors++; $display("FAIL b2b_2: got v=%b pc=%h data=%h exp v=1 pc=00000404 data=00002211",
                               bus.st_valid, bus.st_pc, bus.st_data);
        end
        set_op(OP_SH, 32'h12, 32'h00003344, 32'h0000_0408);
        step();
        checks++;
        if (bus.st_valid !== 1'b1 || bus.st_data !== 32'h33442211 || bus.st_addr !== 32'h10) begin
            errors++; $display("FAIL b2b_3: got v=%b addr=%h data=%h exp v=1 addr=00000010 data=33442211",
                               bus.st_valid, bus.st_addr, bus.st_data);
        end
        set_op(OP_LW, 32'h10, 32'h0, 32'h0);
        checks++;
        if (bus.mem_rdata !== 32'h33442211) begin
            errors++; $display("FAIL b2b_lw: got %h exp 33442211", bus.mem_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid();
        set_op(OP_SW, 32'h0, 32'h11111111, 32'h0000_0500);
        step();
        set_op(OP_SW, 32'h4, 32'h22222222, 32'h0000_0504);
        step();
        set_op(OP_SW, 32'h8, 32'h33333333, 32'h0000_0508);
        step();
        set_op(OP_SW, 32'hC, 32'h44444444, 32'h0000_050C);
        step();
        set_op(OP_SW, 32'h8, 32'h55555555, 32'h0000_0510);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (bus.st_valid !== 1'b0 || bus.st_data !== 32'h0 || bus.st_pc !== 32'h0) begin
            errors++; $display("FAIL midrst_trace: got v=%b pc=%h data=%h exp all 0",
                               bus.st_valid, bus.st_pc, bus.st_data);
        end
        for (int i = 0; i < 4; i++) begin
            set_op(OP_LW, 32'(i * 4), 32'h0, 32'h0);
            checks++;
            if (bus.mem_rdata !== 32'h0) begin
                errors++; $display("FAIL midrst_lw%0d: got %h exp 00000000", i, bus.mem_rdata);
            end
        end
        set_op(OP_LW, 32'h2FFC, 32'h0, 32'h0);
        checks++;
        if (bus.mem_rdata !== 32'h0) begin
            errors++; $display("FAIL midrst_lw_top: got %h exp 00000000", bus.mem_rdata);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        set_nop();
        test_reset();
        test_word_byte();
        test_byte_store();
        test_half();
        test_non_load();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
